// File: rtl/rob_mc_if.sv
// Dispatch, result-bus and retirement signal bundle for rob_mc.
// The master side is dispatch/CDB; the slave side is the reorder buffer.
interface rob_mc_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CDB_N = 2,
  parameter int unsigned RET_W = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
);
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [31:0]            alloc_pc;
  logic [31:0]            alloc_inst;
  logic [PTR_W-1:0]       alloc_id;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*PTR_W-1:0] cdb_id;
  logic [CDB_N*32-1:0]    cdb_wdata;
  logic [CDB_N-1:0]       cdb_mispred;
  logic [CDB_N*32-1:0]    cdb_target;
  logic [RET_W-1:0]       commit_valid;
  logic [RET_W*32-1:0]    commit_pc;
  logic [RET_W*32-1:0]    commit_inst;
  logic [RET_W*32-1:0]    commit_wdata;
  logic [RET_W*64-1:0]    commit_order;
  logic                   flush;
  logic [31:0]            flush_pc;
  logic [PTR_W:0]         count;

  modport master (
    output alloc_valid, alloc_pc, alloc_inst,
    output cdb_valid, cdb_id, cdb_wdata, cdb_mispred, cdb_target,
    input  alloc_ready, alloc_id,
    input  commit_valid, commit_pc, commit_inst, commit_wdata, commit_order,
    input  flush, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_inst,
    input  cdb_valid, cdb_id, cdb_wdata, cdb_mispred, cdb_target,
    output alloc_ready, alloc_id,
    output commit_valid, commit_pc, commit_inst, commit_wdata, commit_order,
    output flush, flush_pc, count
  );
endinterface

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer: in-order allocate, CDB writeback by id,
// up to RET_W in-order retirements per cycle, squash on a mispredicted branch.
module rob_mc #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CDB_N = 2,
  parameter int unsigned RET_W = 2,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input logic     clk,
  input logic     rst_n,
  rob_mc_if.slave bus
);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_ready;
  logic [DEPTH-1:0] ent_mispred;
  logic [31:0]      ent_pc     [DEPTH];
  logic [31:0]      ent_inst   [DEPTH];
  logic [31:0]      ent_wdata  [DEPTH];
  logic [31:0]      ent_target [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [63:0]      order;

  logic             alloc_fire;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] commit_mask;
  logic [CNT_W-1:0] ncommit;
  logic             flush_c;
  logic             lane_go;
  logic [PTR_W-1:0] lane_idx;
  logic [PTR_W-1:0] wb_id [CDB_N];
  logic [CDB_N-1:0] wb_hit;

  assign bus.alloc_ready = (count != CNT_W'(DEPTH)) && !flush_c;
  assign bus.alloc_id    = tail;
  assign bus.count       = count;
  assign bus.flush       = flush_c;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign alloc_mask      = alloc_fire ? (DEPTH'(1) << tail) : '0;

  // A result lands only on an entry that is live and still waiting.
  always_comb begin
    wb_hit = '0;
    for (int unsigned b = 0; b < CDB_N; b++) begin
      wb_id[b]  = bus.cdb_id[b*PTR_W +: PTR_W];
      wb_hit[b] = bus.cdb_valid[b] && ent_valid[wb_id[b]] && !ent_ready[wb_id[b]];
    end
  end

  // Retire contiguous ready entries from head; a mispredict ends the group.
  always_comb begin
    bus.commit_valid = '0;
    bus.commit_pc    = '0;
    bus.commit_inst  = '0;
    bus.commit_wdata = '0;
    bus.commit_order = '0;
    bus.flush_pc     = '0;
    commit_mask      = '0;
    ncommit          = '0;
    flush_c          = 1'b0;
    lane_go          = 1'b1;
    lane_idx         = head;
    for (int unsigned k = 0; k < RET_W; k++) begin
      lane_idx = head + PTR_W'(k);
      if (lane_go && (CNT_W'(k) < count) && ent_valid[lane_idx] && ent_ready[lane_idx]) begin
        bus.commit_valid[k]          = 1'b1;
        bus.commit_pc[k*32 +: 32]    = ent_pc[lane_idx];
        bus.commit_inst[k*32 +: 32]  = ent_inst[lane_idx];
        bus.commit_wdata[k*32 +: 32] = ent_wdata[lane_idx];
        bus.commit_order[k*64 +: 64] = order + 64'(k);
        commit_mask[lane_idx]        = 1'b1;
        ncommit                      = ncommit + CNT_W'(1);
        if (ent_mispred[lane_idx]) begin
          flush_c      = 1'b1;
          bus.flush_pc = ent_target[lane_idx];
          lane_go      = 1'b0;
        end
      end else begin
        lane_go = 1'b0;
      end
    end
  end

  // Control state; descending bus loop lets the lowest bus index win a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid   <= '0;
      ent_ready   <= '0;
      ent_mispred <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      order       <= '0;
    end else begin
      for (int b = int'(CDB_N) - 1; b >= 0; b--) begin
        if (wb_hit[b]) begin
          ent_ready[wb_id[b]]   <= 1'b1;
          ent_mispred[wb_id[b]] <= bus.cdb_mispred[b];
        end
      end
      if (alloc_fire) begin
        ent_ready[tail] <= 1'b0;
      end
      head  <= head + PTR_W'(ncommit);
      order <= order + 64'(ncommit);
      if (flush_c) begin
        ent_valid <= '0;
        tail      <= head + PTR_W'(ncommit);
        count     <= '0;
      end else begin
        ent_valid <= (ent_valid & ~commit_mask) | alloc_mask;
        if (alloc_fire) begin
          tail <= tail + PTR_W'(1);
        end
        count <= count + CNT_W'(alloc_fire) - ncommit;
      end
    end
  end

  // Payload storage; only meaningful while the matching valid/ready bits say so.
  always_ff @(posedge clk) begin
    for (int b = int'(CDB_N) - 1; b >= 0; b--) begin
      if (wb_hit[b]) begin
        ent_wdata[wb_id[b]]  <= bus.cdb_wdata[b*32 +: 32];
        ent_target[wb_id[b]] <= bus.cdb_target[b*32 +: 32];
      end
    end
    if (alloc_fire) begin
      ent_pc[tail]   <= bus.alloc_pc;
      ent_inst[tail] <= bus.alloc_inst;
    end
  end
endmodule
